spi_gyro_target: RTL and testbench
==================================

# spi_gyro_target

SPI target (responder) that emulates the L3G4200D register interface of the PmodGYRO, seen from the device side of the bus. It samples cs/sclk/mosi from an SPI master on the system clock, decodes the command byte, and serves register reads/writes over mode-3 SPI. It provides a synthesizable stand-in for the sensor in board-level loopback and in simulation of the gyro controller. Axis values come from ports so a stimulus source or test pattern can feed them.

## Interface
- WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F
- SYNC_STAGES, 2, flip-flop depth of the cs/sclk/mosi synchronizers (≥2)
- clk  in  1  system clock; must be ≥8× the sclk frequency
- rst  in  1  reset, asynchronous, active-low
- cs  in  1  SPI chip select, active-low
- sclk  in  1  SPI clock, idle high (CPOL=1, CPHA=1)
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master; 0 whenever cs is high
- x_axis_data, y_axis_data, z_axis_data  in  16 each  next sample values
- sample_valid  in  1  one-cycle pulse: load the axis inputs
- ctrl_reg1  out  8  current CTRL_REG1 contents
- busy  out  1  synchronized cs is low

## Operation
- Reset values: miso 0, busy 0, CTRL_REG1 8'h07, CTRL_REG2..5 8'h00, OUT_X/Y/Z 16'h0000, STATUS 8'h00, FSM IDLE.
- FSM states: IDLE → CMD on synced cs fall. CMD → DATA after 8th sclk rise. DATA → DATA on each completed byte. Any state → IDLE on synced cs rise.
- Command byte, MSB first: bit7 RW (1=read), bit6 MS (1=auto-increment), bits5:0 address.
- Auto-increment: with MS=1 the address increments after each data byte and wraps 6'h3F→6'h00. With MS=0 it stays fixed.
- Register map:
  - 0x0F WHO_AM_I (RO)
  - 0x20–0x24 CTRL_REG1–5 (RW)
  - 0x27 STATUS (RO): bit3 ZYXDA, bit7 ZYXOR
  - 0x28–0x2D OUT_X_L, X_H, Y_L, Y_H, Z_L, Z_H (RO)
  - All other addresses read 8'h00.
- Writes to RO or unmapped addresses are ignored.
- Write commit: a data byte is written on its 8th sclk rise. A partial byte (cs rises mid-byte) is discarded.
- Read: the register byte is loaded into the shift-out register at the byte boundary. miso presents its MSB on the next synced sclk fall, then shifts one bit per fall.
- Sample load:
  - sample_valid while busy=0 updates OUT_* immediately.
  - sample_valid while busy=1 is held pending (latest value wins) and applied the cycle after cs rises. This keeps multi-byte reads coherent.
  - Each load sets ZYXDA. A load with ZYXDA already set also sets ZYXOR.
- STATUS clear: completing a read byte of OUT_Z_H (0x2D) clears ZYXDA and ZYXOR. If a load and a clear coincide, the set wins.

## Timing
- Input path: SYNC_STAGES sync flops, then 1 edge-detect flop. Edges act SYNC_STAGES+1 clk after the pin change.
- mosi is captured on the synced sclk rise, using the mosi sample from the same synchronizer stage.
- miso updates within SYNC_STAGES+2 clk of the sclk falling pin edge, which must be < half an sclk period.
- Write to CTRL_REG1 is visible on ctrl_reg1 one clk after the 8th rise of the data byte.
- busy follows cs with SYNC_STAGES clk of latency.
- Reset mid-transfer: all registers return to reset values. The FSM stays in IDLE until the next cs fall is seen with rst high.
- cs fall and sclk edge in the same synced cycle: cs fall takes precedence and the bit counter restarts at 0.

## Structure
- Package gyro_pkg:
  - register address localparams (ADDR_WHO_AM_I, ADDR_CTRL1..5, ADDR_STATUS, ADDR_OUT_XL..ZH)
  - CTRL1_RST = 8'h07
  - FSM state enum (IDLE, CMD, DATA)
  - RW/MS bit indices
- Sub-module spi_sync_edge: parameterized SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiate it once per input (cs, sclk, mosi; mosi uses the level output only).

## Test plan
- Reset, then read 0x8F at sclk = clk/16 → miso returns 8'hD3; ctrl_reg1 = 8'h07.
- Write 0x20 with 8'h0F → ctrl_reg1 = 8'h0F one clk after the 8th data rise; reading 0xA0 returns 8'h0F.
- sample_valid with x=16'h1234, y=16'h5678, z=16'h9ABC, then burst read 0xE8 for 6 bytes → 34 12 78 56 BC 9A. STATUS reads 8'h08 before the burst and 8'h00 after it.
- Two sample_valid pulses with no read in between → STATUS = 8'h88.
- sample_valid during a 0xE8 burst → bytes keep the old sample; the new one is applied after cs rises.
- cs raised after 4 bits of a write to 0x21 → CTRL_REG2 stays 8'h00.
- Assert rst mid-burst → miso 0, FSM IDLE, CTRL_REG1 back to 8'h07.
- Write to 0x0F → ignored; WHO_AM_I still reads 8'hD3.
- Read 0x3F with MS=1 for 2 bytes → address wraps to 0x00; both bytes 8'h00.

Source files
------------

// File: rtl/gyro_pkg.sv
// Shared definitions for the emulated L3G4200D register interface.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package gyro_pkg;

  // Register map
  localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
  localparam logic [5:0] ADDR_CTRL1    = 6'h20;
  localparam logic [5:0] ADDR_CTRL2    = 6'h21;
  localparam logic [5:0] ADDR_CTRL3    = 6'h22;
  localparam logic [5:0] ADDR_CTRL4    = 6'h23;
  localparam logic [5:0] ADDR_CTRL5    = 6'h24;
  localparam logic [5:0] ADDR_STATUS   = 6'h27;
  localparam logic [5:0] ADDR_OUT_XL   = 6'h28;
  localparam logic [5:0] ADDR_OUT_XH   = 6'h29;
  localparam logic [5:0] ADDR_OUT_YL   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_YH   = 6'h2B;
  localparam logic [5:0] ADDR_OUT_ZL   = 6'h2C;
  localparam logic [5:0] ADDR_OUT_ZH   = 6'h2D;

  localparam logic [7:0] CTRL1_RST = 8'h07;

  // Command byte fields
  localparam int RW_BIT = 7;
  localparam int MS_BIT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered-edge detection for one async input.
// Latency: level after SYNC_STAGES clk; rise/fall pulses valid the cycle after.
// Backpressure: none (free-running sampler).
// Ports: clk/rst (async active-low), din (async pin), level (synced value),
//        rise/fall (one-cycle pulses on synced transitions).
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_gyro_target.sv
// Mode-3 SPI responder emulating the L3G4200D gyro register file.
// Latency: edges act SYNC_STAGES+1 clk after the pin; miso within SYNC_STAGES+2 clk of sclk fall.
// Backpressure: none; clk must be >= 8x sclk. Samples arriving mid-transfer are held until cs rises.
// Ports: clk/rst (async active-low); cs/sclk/mosi/miso SPI pins; x/y/z_axis_data + sample_valid
//        load the OUT registers; ctrl_reg1 mirrors CTRL_REG1; busy = synchronized cs low.
module spi_gyro_target
  import gyro_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] x_axis_data,
  input  logic [15:0] y_axis_data,
  input  logic [15:0] z_axis_data,
  input  logic        sample_valid,
  output logic [7:0]  ctrl_reg1,
  output logic        busy
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sigs;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  // mosi goes through the same depth so it lines up with the synced sclk rise
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sigs = ^{sclk_lvl, mosi_rise, mosi_fall};

  spi_state_t       state, state_n;
  logic [2:0]       bit_cnt;
  logic [7:0]       shin, shout;
  logic [5:0]       addr;
  logic             rw, ms;
  logic             miso_q;
  logic [4:0][7:0]  ctrl_q;
  logic [5:0][7:0]  out_q;
  logic             zyxda, zyxor;
  logic             pend_vld;
  logic [15:0]      pend_x, pend_y, pend_z;

  logic             active, byte_done, data_wr, clr_status;
  logic             load_now, load;
  logic [7:0]       rx_byte, rd_data;
  logic [5:0]       next_addr, rd_addr;
  logic [15:0]      ld_x, ld_y, ld_z;

  // A cs rise in the same cycle as an sclk edge ends the transfer, so the
  // edge is ignored and any partial byte is dropped.
  assign active     = (state != IDLE) && !cs_rise;
  assign byte_done  = active && sclk_rise && (bit_cnt == 3'd7);
  assign rx_byte    = {shin[6:0], mosi_lvl};
  assign next_addr  = ms ? addr + 6'd1 : addr;
  // Command byte: prefetch its own address; data byte: prefetch the next one.
  assign rd_addr    = (state == CMD) ? rx_byte[5:0] : next_addr;
  assign data_wr    = byte_done && (state == DATA) && !rw;
  assign clr_status = byte_done && (state == DATA) && rw && (addr == ADDR_OUT_ZH);

  // Pending samples are only captured while busy, so applying one whenever
  // busy is low is the cycle after cs rises. A fresh sample at that instant wins.
  assign load_now = sample_valid && !busy;
  assign load     = load_now || (pend_vld && !busy);
  assign ld_x     = load_now ? x_axis_data : pend_x;
  assign ld_y     = load_now ? y_axis_data : pend_y;
  assign ld_z     = load_now ? z_axis_data : pend_z;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      ADDR_WHO_AM_I: rd_data = WHO_AM_I_VAL;
      ADDR_CTRL1:    rd_data = ctrl_q[0];
      ADDR_CTRL2:    rd_data = ctrl_q[1];
      ADDR_CTRL3:    rd_data = ctrl_q[2];
      ADDR_CTRL4:    rd_data = ctrl_q[3];
      ADDR_CTRL5:    rd_data = ctrl_q[4];
      ADDR_STATUS:   rd_data = {zyxor, 3'b000, zyxda, 3'b000};
      ADDR_OUT_XL:   rd_data = out_q[0];
      ADDR_OUT_XH:   rd_data = out_q[1];
      ADDR_OUT_YL:   rd_data = out_q[2];
      ADDR_OUT_YH:   rd_data = out_q[3];
      ADDR_OUT_ZL:   rd_data = out_q[4];
      ADDR_OUT_ZH:   rd_data = out_q[5];
      default:       rd_data = 8'h00;
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cs_fall) state_n = CMD;
      CMD:     if (byte_done) state_n = DATA;
      DATA:    state_n = DATA;
      default: state_n = IDLE;
    endcase
    if (cs_rise) state_n = IDLE;
  end

  // Shift datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= 3'd0;
      shin    <= 8'h00;
      shout   <= 8'h00;
      addr    <= 6'h00;
      rw      <= 1'b0;
      ms      <= 1'b0;
      miso_q  <= 1'b0;
    end else if (cs_fall) begin
      bit_cnt <= 3'd0;
      shout   <= 8'h00;
      miso_q  <= 1'b0;
    end else if (cs_rise) begin
      bit_cnt <= 3'd0;
      miso_q  <= 1'b0;
    end else if (active) begin
      if (sclk_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        shin    <= rx_byte;
        if (byte_done) begin
          if (state == CMD) begin
            rw   <= rx_byte[RW_BIT];
            ms   <= rx_byte[MS_BIT];
            addr <= rx_byte[5:0];
          end else begin
            addr <= next_addr;
          end
          if ((state == CMD && rx_byte[RW_BIT]) || (state == DATA && rw))
            shout <= rd_data;
        end
      end
      if (sclk_fall) begin
        miso_q <= shout[7];
        shout  <= {shout[6:0], 1'b0};
      end
    end
  end

  // Control registers; writes to anything outside CTRL1..5 fall through.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= {8'h00, 8'h00, 8'h00, 8'h00, CTRL1_RST};
    end else if (data_wr) begin
      case (addr)
        ADDR_CTRL1: ctrl_q[0] <= rx_byte;
        ADDR_CTRL2: ctrl_q[1] <= rx_byte;
        ADDR_CTRL3: ctrl_q[2] <= rx_byte;
        ADDR_CTRL4: ctrl_q[3] <= rx_byte;
        ADDR_CTRL5: ctrl_q[4] <= rx_byte;
        default: ;
      endcase
    end
  end

  // Sample holding, output registers and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld <= 1'b0;
      pend_x   <= 16'h0000;
      pend_y   <= 16'h0000;
      pend_z   <= 16'h0000;
      out_q    <= '0;
      zyxda    <= 1'b0;
      zyxor    <= 1'b0;
    end else begin
      if (sample_valid && busy) begin
        pend_vld <= 1'b1;
        pend_x   <= x_axis_data;
        pend_y   <= y_axis_data;
        pend_z   <= z_axis_data;
      end else if (!busy) begin
        pend_vld <= 1'b0;
      end
      if (load) begin
        out_q <= {ld_z[15:8], ld_z[7:0], ld_y[15:8], ld_y[7:0], ld_x[15:8], ld_x[7:0]};
        zyxda <= 1'b1;
        zyxor <= zyxor | zyxda;
      end else if (clr_status) begin
        zyxda <= 1'b0;
        zyxor <= 1'b0;
      end
    end
  end

  assign busy      = ~cs_lvl;
  assign miso      = miso_q & ~cs_lvl;
  assign ctrl_reg1 = ctrl_q[0];

endmodule

// File: tb/tb_spi_gyro_target.sv
// Scoreboard bench for spi_gyro_target: SPI master tasks at sclk = clk/16,
// a register model that predicts read bytes at drive time, and a queue
// that is drained as bytes come back on miso.
module tb_spi_gyro_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, sclk, mosi;
  logic        miso;
  logic [15:0] x_axis_data, y_axis_data, z_axis_data;
  logic        sample_valid;
  logic [7:0]  ctrl_reg1;
  logic        busy;

  spi_gyro_target #(.WHO_AM_I_VAL(8'hD3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .x_axis_data(x_axis_data), .y_axis_data(y_axis_data), .z_axis_data(z_axis_data),
    .sample_valid(sample_valid), .ctrl_reg1(ctrl_reg1), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // Register model
  logic [7:0] m_ctrl [5];
  logic [7:0] m_out  [6];
  logic [7:0] m_stat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_ctrl[0] = 8'h07;
    for (int i = 1; i < 5; i++) m_ctrl[i] = 8'h00;
    for (int i = 0; i < 6; i++) m_out[i] = 8'h00;
    m_stat = 8'h00;
  endtask

  task automatic mdl_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    if (m_stat[3]) m_stat[7] = 1'b1;
    m_stat[3] = 1'b1;
    m_out[0] = x[7:0]; m_out[1] = x[15:8];
    m_out[2] = y[7:0]; m_out[3] = y[15:8];
    m_out[4] = z[7:0]; m_out[5] = z[15:8];
  endtask

  function automatic logic [7:0] mdl_rd(input logic [5:0] a);
    if (a == 6'h0F) return 8'hD3;
    if (a >= 6'h20 && a <= 6'h24) return m_ctrl[a - 6'h20];
    if (a == 6'h27) return m_stat;
    if (a >= 6'h28 && a <= 6'h2D) return m_out[a - 6'h28];
    return 8'h00;
  endfunction

  // Push expected read bytes for a command and advance the model.
  task automatic push_rd(input logic [7:0] cmd, input int n);
    logic [5:0] a;
    a = cmd[5:0];
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mdl_rd(a));
      if (a == 6'h2D) m_stat = 8'h00;
      if (cmd[6]) a = a + 6'd1;
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] rx);
    if (exp_q.size() == 0) chk({tag, "_qempty"}, 1, 0);
    else chk(tag, {24'h0, rx}, {24'h0, exp_q.pop_front()});
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    #80;
  endtask

  task automatic cs_hi();
    #80;
    cs = 1'b1;
    #160;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = tx[i];
      #80;
      rx[i] = miso;
      sclk = 1'b1;
      #80;
    end
  endtask

  task automatic rd_burst(input string tag, input logic [7:0] cmd, input int n);
    logic [7:0] rx;
    push_rd(cmd, n);
    cs_lo();
    xfer(cmd, rx);
    for (int k = 0; k < n; k++) begin
      xfer(8'h00, rx);
      pop_chk(tag, rx);
    end
    cs_hi();
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    logic [7:0] rx;
    cs_lo();
    xfer({2'b00, a}, rx);
    xfer(d, rx);
    cs_hi();
    if (a >= 6'h20 && a <= 6'h24) m_ctrl[a - 6'h20] = d;
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    x_axis_data  = x;
    y_axis_data  = y;
    z_axis_data  = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    #40;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic [7:0] d;

    rst = 1'b0; cs = 1'b1; sclk = 1'b1; mosi = 1'b0;
    x_axis_data = '0; y_axis_data = '0; z_axis_data = '0; sample_valid = 1'b0;
    mdl_reset();
    #40;
    chk("rst_miso", miso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl1", ctrl_reg1, 8'h07);
    rst = 1'b1;
    #100;

    // WHO_AM_I
    rd_burst("whoami", 8'h8F, 1);
    chk("ctrl1_init", ctrl_reg1, 8'h07);
    chk("miso_idle", miso, 0);

    // CTRL_REG1 write with commit timing around the 8th data rise
    cs_lo();
    xfer(8'h20, rx);
    d = 8'h0F;
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = d[i];
      #80;
      sclk = 1'b1;
      if (i == 0) begin
        #15;
        chk("ctrl1_before_commit", ctrl_reg1, 8'h07);
        #25;
        chk("ctrl1_after_commit", ctrl_reg1, 8'h0F);
        #40;
      end else begin
        #80;
      end
    end
    cs_hi();
    m_ctrl[0] = 8'h0F;
    rd_burst("rd_ctrl1", 8'hA0, 1);

    // Sample load then burst read of all axes
    pulse_sample(16'h1234, 16'h5678, 16'h9ABC);
    mdl_load(16'h1234, 16'h5678, 16'h9ABC);
    rd_burst("status_new", 8'hA7, 1);
    rd_burst("burst_a", 8'hE8, 6);
    rd_burst("status_clr", 8'hA7, 1);

    // Overrun
    pulse_sample(16'h0102, 16'h0304, 16'h0506);
    mdl_load(16'h0102, 16'h0304, 16'h0506);
    pulse_sample(16'hA1B2, 16'hC3D4, 16'hE5F6);
    mdl_load(16'hA1B2, 16'hC3D4, 16'hE5F6);
    rd_burst("status_ovr", 8'hA7, 1);
    rd_burst("burst_ovr", 8'hE8, 6);

    // Sample arriving mid-burst must not tear the read
    pulse_sample(16'h1111, 16'h2222, 16'h3333);
    mdl_load(16'h1111, 16'h2222, 16'h3333);
    push_rd(8'hE8, 6);
    cs_lo();
    xfer(8'hE8, rx);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        chk("busy_in_burst", busy, 1);
        @(negedge clk);
        x_axis_data = 16'h4444; y_axis_data = 16'h5555; z_axis_data = 16'h6666;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
      end
      xfer(8'h00, rx);
      pop_chk("burst_coherent", rx);
    end
    cs_hi();
    mdl_load(16'h4444, 16'h5555, 16'h6666);
    rd_burst("status_pend", 8'hA7, 1);
    rd_burst("burst_pend", 8'hE8, 6);

    // Partial write to CTRL_REG2 is discarded
    cs_lo();
    xfer(8'h21, rx);
    for (int i = 0; i < 4; i++) begin
      sclk = 1'b0; mosi = 1'b1; #80;
      sclk = 1'b1; #80;
    end
    cs_hi();
    rd_burst("ctrl2_partial", 8'hA1, 1);

    // Reset mid-burst
    pulse_sample(16'hDEAD, 16'hBEEF, 16'hCAFE);
    mdl_load(16'hDEAD, 16'hBEEF, 16'hCAFE);
    push_rd(8'hE8, 2);
    cs_lo();
    xfer(8'hE8, rx);
    for (int k = 0; k < 2; k++) begin
      xfer(8'h00, rx);
      pop_chk("burst_prerst", rx);
    end
    sclk = 1'b0;
    #40;
    rst = 1'b0;
    #20;
    chk("midrst_miso", miso, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ctrl1", ctrl_reg1, 8'h07);
    sclk = 1'b1;
    cs = 1'b1;
    #20;
    rst = 1'b1;
    mdl_reset();
    #200;
    rd_burst("post_rst_whoami", 8'h8F, 1);
    rd_burst("post_rst_status", 8'hA7, 1);
    rd_burst("post_rst_out", 8'hE8, 6);
    rd_burst("post_rst_ctrl1", 8'hA0, 1);

    // Write to read-only WHO_AM_I is ignored
    wr(6'h0F, 8'h55);
    rd_burst("whoami_ro", 8'h8F, 1);

    // CTRL_REG3 plain write/read and auto-increment wrap at 0x3F
    wr(6'h22, 8'hA5);
    rd_burst("ctrl3_rw", 8'hE0, 5);
    rd_burst("wrap_3f", 8'hFF, 2);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
